draw_screen_fader: RTL and testbench

Parametrised VGA screen selector with frame-synchronous fade transitions. It sits at the end of the draw pipeline: it takes N per-screen VGA streams (start, gameplay, win screens and any added later) and a screen-select code from the game FSM. It forwards the active stream and, on a select change, fades the picture to black, switches source at a frame boundary, then fades back in.

---
 rtl/draw_screen_fader.sv | 162 ++++++++++++++++
 tb/tb_draw_screen_fader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_screen_fader.sv
// End-of-pipeline VGA screen selector: forwards one of N_SRC streams and crossfades through black
// on a select change, stepping brightness only at frame boundaries of the displayed source.
module draw_screen_fader #(
   parameter int unsigned N_SRC      = 4,
   parameter int unsigned FADE_SHIFT = 2,
   parameter int unsigned SEL_W      = $clog2(N_SRC)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [SEL_W-1:0]       i_sel,
   input  logic [N_SRC*11-1:0]    i_src_hcount,
   input  logic [N_SRC*11-1:0]    i_src_vcount,
   input  logic [N_SRC-1:0]       i_src_hsync,
   input  logic [N_SRC-1:0]       i_src_vsync,
   input  logic [N_SRC-1:0]       i_src_hblnk,
   input  logic [N_SRC-1:0]       i_src_vblnk,
   input  logic [N_SRC*12-1:0]    i_src_rgb,
   output logic [10:0]            o_hcount,
   output logic [10:0]            o_vcount,
   output logic                   o_hsync,
   output logic                   o_vsync,
   output logic                   o_hblnk,
   output logic                   o_vblnk,
   output logic [11:0]            o_rgb,
   output logic [SEL_W-1:0]       o_active_idx,
   output logic                   o_busy
);

   localparam int unsigned LvlW   = FADE_SHIFT + 1;
   localparam int unsigned ProdW  = FADE_SHIFT + 5;
   localparam logic [FADE_SHIFT:0] LvlMax = LvlW'(1 << FADE_SHIFT);

   typedef enum logic [1:0] {StIdle, StFadeOut, StFadeIn} state_e;

   state_e                r_state, w_state_next;
   logic [FADE_SHIFT:0]   r_level, w_level_next;
   logic [SEL_W-1:0]      r_active_idx, w_active_next;
   logic [SEL_W-1:0]      w_sel_s;
   logic                  r_vblnk_prev;
   logic                  w_vblnk_cur;
   logic                  w_fe;
   logic [FADE_SHIFT:0]   w_level_inc;
   logic [FADE_SHIFT:0]   w_level_dec;

   logic [10:0]           r_s1_hcount, r_s1_vcount;
   logic                  r_s1_hsync, r_s1_vsync, r_s1_hblnk, r_s1_vblnk;
   logic [11:0]           r_s1_rgb;
   logic [ProdW-1:0]      w_prod [3];
   logic [11:0]           w_rgb_scaled;

   always_comb begin
      w_sel_s = (32'(i_sel) < N_SRC) ? i_sel : '0;
   end

   assign w_vblnk_cur = i_src_vblnk[r_active_idx];
   assign w_fe        = w_vblnk_cur & ~r_vblnk_prev;
   assign w_level_inc = r_level + 1'b1;
   assign w_level_dec = r_level - 1'b1;

   always_comb begin
      w_state_next  = r_state;
      w_level_next  = r_level;
      w_active_next = r_active_idx;
      if (w_fe) begin
         unique case (r_state)
            StIdle: begin
               if (w_sel_s != r_active_idx) begin
                  w_state_next = StFadeOut;
                  w_level_next = w_level_dec;
               end
            end
            StFadeOut: begin
               if (w_sel_s == r_active_idx) begin
                  // Abort: climb back from wherever the fade-out got to.
                  w_level_next = w_level_inc;
                  w_state_next = (w_level_inc == LvlMax) ? StIdle : StFadeIn;
               end else if (r_level == LvlW'(1)) begin
                  w_level_next  = '0;
                  w_active_next = w_sel_s;
                  w_state_next  = StFadeIn;
               end else begin
                  w_level_next = w_level_dec;
               end
            end
            StFadeIn: begin
               w_level_next = w_level_inc;
               if (w_level_inc == LvlMax) begin
                  w_state_next = StIdle;
               end
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= StIdle;
         r_level      <= LvlMax;
         r_active_idx <= '0;
         r_vblnk_prev <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_level      <= w_level_next;
         r_active_idx <= w_active_next;
         r_vblnk_prev <= w_vblnk_cur;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_s1_hcount <= '0;
         r_s1_vcount <= '0;
         r_s1_hsync  <= 1'b0;
         r_s1_vsync  <= 1'b0;
         r_s1_hblnk  <= 1'b0;
         r_s1_vblnk  <= 1'b0;
         r_s1_rgb    <= '0;
      end else begin
         r_s1_hcount <= i_src_hcount[32'(r_active_idx) * 11 +: 11];
         r_s1_vcount <= i_src_vcount[32'(r_active_idx) * 11 +: 11];
         r_s1_hsync  <= i_src_hsync[r_active_idx];
         r_s1_vsync  <= i_src_vsync[r_active_idx];
         r_s1_hblnk  <= i_src_hblnk[r_active_idx];
         r_s1_vblnk  <= i_src_vblnk[r_active_idx];
         r_s1_rgb    <= i_src_rgb[32'(r_active_idx) * 12 +: 12];
      end
   end

   // Truncating scale; level == LvlMax reproduces the input exactly.
   always_comb begin
      w_rgb_scaled = '0;
      for (int ch = 0; ch < 3; ch++) begin
         w_prod[ch] = ProdW'(r_s1_rgb[ch*4 +: 4]) * ProdW'(r_level);
         w_rgb_scaled[ch*4 +: 4] = 4'(w_prod[ch] >> FADE_SHIFT);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_hcount <= '0;
         o_vcount <= '0;
         o_hsync  <= 1'b0;
         o_vsync  <= 1'b0;
         o_hblnk  <= 1'b0;
         o_vblnk  <= 1'b0;
         o_rgb    <= '0;
      end else begin
         o_hcount <= r_s1_hcount;
         o_vcount <= r_s1_vcount;
         o_hsync  <= r_s1_hsync;
         o_vsync  <= r_s1_vsync;
         o_hblnk  <= r_s1_hblnk;
         o_vblnk  <= r_s1_vblnk;
         o_rgb    <= (r_s1_hblnk | r_s1_vblnk) ? 12'h000 : w_rgb_scaled;
      end
   end

   assign o_active_idx = r_active_idx;
   assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_draw_screen_fader.sv
// Directed bench for draw_screen_fader: a tiny 16x8 raster feeds every source; fades are
// checked frame by frame, pass-through latency through a queue of driven pixels.
module tb_draw_screen_fader;

   localparam int N     = 4;
   localparam int N3    = 3;
   localparam int H_TOT = 16;
   localparam int H_VIS = 12;
   localparam int V_TOT = 8;
   localparam int V_VIS = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        sel, sel3;
   logic [N*11-1:0]   hc, vc;
   logic [N-1:0]      hs, vs, hb, vb;
   logic [N*12-1:0]   rgb;
   logic [N3*11-1:0]  hc3, vc3;
   logic [N3-1:0]     hs3, vs3, hb3, vb3;
   logic [N3*12-1:0]  rgb3;

   logic [10:0] o_hcount, o_vcount, o_hcount3, o_vcount3;
   logic        o_hsync, o_vsync, o_hblnk, o_vblnk, o_busy;
   logic        o_hsync3, o_vsync3, o_hblnk3, o_vblnk3, o_busy3;
   logic [11:0] o_rgb, o_rgb3;
   logic [1:0]  o_act, o_act3;

   always #5 clk = ~clk;

   draw_screen_fader #(.N_SRC(N), .FADE_SHIFT(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_sel(sel),
      .i_src_hcount(hc), .i_src_vcount(vc), .i_src_hsync(hs), .i_src_vsync(vs),
      .i_src_hblnk(hb), .i_src_vblnk(vb), .i_src_rgb(rgb),
      .o_hcount(o_hcount), .o_vcount(o_vcount), .o_hsync(o_hsync), .o_vsync(o_vsync),
      .o_hblnk(o_hblnk), .o_vblnk(o_vblnk), .o_rgb(o_rgb), .o_active_idx(o_act),
      .o_busy(o_busy)
   );

   draw_screen_fader #(.N_SRC(N3), .FADE_SHIFT(2)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_sel(sel3),
      .i_src_hcount(hc3), .i_src_vcount(vc3), .i_src_hsync(hs3), .i_src_vsync(vs3),
      .i_src_hblnk(hb3), .i_src_vblnk(vb3), .i_src_rgb(rgb3),
      .o_hcount(o_hcount3), .o_vcount(o_vcount3), .o_hsync(o_hsync3), .o_vsync(o_vsync3),
      .o_hblnk(o_hblnk3), .o_vblnk(o_vblnk3), .o_rgb(o_rgb3), .o_active_idx(o_act3),
      .o_busy(o_busy3)
   );

   typedef struct {
      logic [10:0] hc;
      logic [11:0] rgb;
   } exp_t;

   exp_t        q[$];
   bit          sb_on;
   int          checks;
   int          errors;
   int          h, v;
   logic        pvb;
   logic        force_hb;
   logic [11:0] col  [4];
   logic [11:0] col3 [3];
   logic [11:0] t2_rgb [8];
   logic [11:0] t5_rgb [9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         hc[s*11 +: 11]  = 11'(h);
         vc[s*11 +: 11]  = 11'(v);
         hs[s]           = (h >= 13 && h < 15);
         vs[s]           = (v == 7);
         hb[s]           = (h >= H_VIS) || force_hb;
         vb[s]           = (v >= V_VIS);
         rgb[s*12 +: 12] = col[s];
      end
      for (int s = 0; s < N3; s++) begin
         hc3[s*11 +: 11]  = 11'(h);
         vc3[s*11 +: 11]  = 11'(v);
         hs3[s]           = (h >= 13 && h < 15);
         vs3[s]           = (v == 7);
         hb3[s]           = (h >= H_VIS);
         vb3[s]           = (v >= V_VIS);
         rgb3[s*12 +: 12] = col3[s];
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (sb_on && q.size() >= 2) begin
         e = q.pop_front();
         chk("sb_hcount", 32'(o_hcount), 32'(e.hc));
         chk("sb_rgb", 32'(o_rgb), 32'(e.rgb));
      end
      pvb = (v >= V_VIS);
      h++;
      if (h == H_TOT) begin
         h = 0;
         v++;
         if (v == V_TOT) v = 0;
      end
      drive();
      if (sb_on) begin
         e.hc  = 11'(h);
         e.rgb = ((h >= H_VIS) || force_hb || (v >= V_VIS)) ? 12'h000 : col[0];
         q.push_back(e);
      end
   endtask

   task automatic wait_edge();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(!pvb && v >= V_VIS) && n < 2 * H_TOT * V_TOT);
      if (n >= 2 * H_TOT * V_TOT) begin
         checks++;
         errors++;
         $display("FAIL edge_timeout: observed no vblnk edge, expected one");
      end
   endtask

   task automatic goto_pos(input int th, input int tv);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(h == th && v == tv) && n < 2 * H_TOT * V_TOT);
   endtask

   // Sample mid-frame: outputs reflect a visible pixel two ticks back.
   task automatic check_frame(input string tag, input logic [11:0] exp_rgb,
                              input logic [1:0] exp_act, input logic exp_busy);
      goto_pos(5, 2);
      chk({tag, "_rgb"}, 32'(o_rgb), 32'(exp_rgb));
      chk({tag, "_act"}, 32'(o_act), 32'(exp_act));
      chk({tag, "_busy"}, 32'(o_busy), 32'(exp_busy));
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      sb_on    = 0;
      h        = 0;
      v        = 0;
      pvb      = 1'b0;
      force_hb = 1'b0;
      col[0] = 12'hABC; col[1] = 12'h123; col[2] = 12'hFFF; col[3] = 12'h888;
      col3[0] = 12'h5A3; col3[1] = 12'h111; col3[2] = 12'h222;
      t2_rgb = '{12'hBBB, 12'h777, 12'h333, 12'h000, 12'h333, 12'h777, 12'hBBB, 12'hFFF};
      t5_rgb = '{12'hBBB, 12'h777, 12'h333, 12'h000, 12'h222, 12'h444, 12'h666, 12'h888,
                 12'h666};
      rst  = 1'b0;
      sel  = 2'd0;
      sel3 = 2'd3;
      drive();

      // Reset state
      repeat (3) tick();
      chk("rst_hcount", 32'(o_hcount), 0);
      chk("rst_vcount", 32'(o_vcount), 0);
      chk("rst_hsync", 32'(o_hsync), 0);
      chk("rst_vsync", 32'(o_vsync), 0);
      chk("rst_hblnk", 32'(o_hblnk), 0);
      chk("rst_vblnk", 32'(o_vblnk), 0);
      chk("rst_rgb", 32'(o_rgb), 0);
      chk("rst_act", 32'(o_act), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_rgb3", 32'(o_rgb3), 0);

      // Pass-through with 2-cycle lag, including forced horizontal blanking
      rst = 1'b1;
      q.delete();
      sb_on = 1;
      repeat (40) tick();
      goto_pos(4, 3);
      force_hb = 1'b1;
      repeat (3) tick();
      chk("blank_rgb", 32'(o_rgb), 0);
      force_hb = 1'b0;
      repeat (4) tick();
      chk("pass_busy", 32'(o_busy), 0);
      sb_on = 0;
      q.delete();

      // Full fade 0 -> 2
      col[0] = 12'hFFF;
      sel = 2'd2;
      for (int k = 0; k < 8; k++) begin
         wait_edge();
         check_frame($sformatf("fade_e%0d", k + 1), t2_rgb[k], (k >= 3) ? 2'd2 : 2'd0,
                     (k < 7));
      end
      chk("oor3_rgb", 32'(o_rgb3), 32'(col3[0]));
      chk("oor3_busy", 32'(o_busy3), 0);

      // Reset in the middle of a fade-out at L = 1
      sel = 2'd1;
      wait_edge(); check_frame("rmf_e1", 12'hBBB, 2'd2, 1'b1);
      wait_edge(); check_frame("rmf_e2", 12'h777, 2'd2, 1'b1);
      wait_edge(); check_frame("rmf_e3", 12'h333, 2'd2, 1'b1);
      rst = 1'b0;
      sel = 2'd0;
      repeat (3) tick();
      chk("rmf_rgb", 32'(o_rgb), 0);
      chk("rmf_hcount", 32'(o_hcount), 0);
      chk("rmf_act", 32'(o_act), 0);
      chk("rmf_busy", 32'(o_busy), 0);
      rst = 1'b1;
      check_frame("rmf_after", 12'hFFF, 2'd0, 1'b0);

      // Abort a 0 -> 1 fade after e2
      sel = 2'd1;
      wait_edge(); check_frame("abort_e1", 12'hBBB, 2'd0, 1'b1);
      wait_edge(); check_frame("abort_e2", 12'h777, 2'd0, 1'b1);
      sel = 2'd0;
      wait_edge(); check_frame("abort_e3", 12'hBBB, 2'd0, 1'b1);
      wait_edge(); check_frame("abort_e4", 12'hFFF, 2'd0, 1'b0);

      // Retarget during fade-out, late request during fade-in
      sel = 2'd1;
      for (int k = 0; k < 9; k++) begin
         if (k == 3) sel = 2'd3;
         if (k == 5) sel = 2'd2;
         wait_edge();
         check_frame($sformatf("retgt_e%0d", k + 1), t5_rgb[k], (k >= 3) ? 2'd3 : 2'd0,
                     (k != 7));
      end

      // Out-of-range select on the 3-source instance never moved it
      chk("oor3_rgb_end", 32'(o_rgb3), 32'(col3[0]));
      chk("oor3_act", 32'(o_act3), 0);
      chk("oor3_busy_end", 32'(o_busy3), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
